// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: emits a commanded number of A/B edges at a
// programmable period in either direction and mirrors the resulting position.
module quad_encoder_gen #(
  parameter int          DIV_W    = 16,
  parameter int          STEP_W   = 16,
  parameter logic [15:0] POS_INIT = 16'h8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [STEP_W-1:0] nsteps,
  input  logic [DIV_W-1:0]  period,
  input  logic              abort,
  output logic              encA,
  output logic              encB,
  output logic [15:0]       pos,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic              dir_q;
  logic [DIV_W-1:0]  period_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [STEP_W-1:0] remain;
  logic [DIV_W-1:0]  period_eff;
  logic              edge_due;

  // A zero period would stall the divider forever, so it runs at one edge per clock.
  assign period_eff = (period == '0) ? DIV_W'(1) : period;
  assign edge_due   = (div_cnt == DIV_W'(1));

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      encA     <= 1'b0;
      encB     <= 1'b0;
      pos      <= POS_INIT;
      busy     <= 1'b0;
      done     <= 1'b0;
      dir_q    <= 1'b0;
      period_q <= '0;
      div_cnt  <= '0;
      remain   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dir_q    <= dir;
            period_q <= period_eff;
            div_cnt  <= period_eff;
            remain   <= nsteps;
            if (nsteps == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (edge_due) begin
            div_cnt <= period_q;
            remain  <= remain - STEP_W'(1);
            // Forward walks 00->10->11->01, reverse walks the opposite way.
            if (dir_q) begin
              encA <= ~encB;
              encB <= encA;
              pos  <= pos + 16'd1;
            end else begin
              encA <= encB;
              encB <= ~encA;
              pos  <= pos - 16'd1;
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
          // A due edge is still emitted in the abort cycle.
          if ((edge_due && remain == STEP_W'(1)) || abort) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: per-cycle comparison against a move-level model,
// a bench-side 4x reader for loopback, and directed literal checks.
module tb_quad_encoder_gen;

  logic        clk = 1'b0;
  logic        rst, start, dir, abort;
  logic [15:0] nsteps, period;
  logic        encA, encB, busy, done;
  logic [15:0] pos;

  quad_encoder_gen dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .nsteps(nsteps),
    .period(period), .abort(abort), .encA(encA), .encB(encB), .pos(pos),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Move-level model: phase is an index into the forward cycle of {A,B}.
  logic [1:0]  ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int          cyc = 0;
  bit          armed = 0;
  int          m_mode, m_s, m_p, m_n, m_emit, m_phase;
  bit          m_dir, m_busy, m_done;
  logic [15:0] m_pos;

  // Bench-side 4x reader fed from encA/encB.
  int          rd_prev;
  logic [15:0] rd_cnt, lag_pos;
  int          done_cnt = 0;
  int          busy_cnt = 0;

  function automatic int ab_idx(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      armed   = 1;
      m_mode  = 0;
      m_phase = 0;
      m_pos   = 16'h8000;
      m_busy  = 0;
      m_done  = 0;
      rd_prev = 0;
      rd_cnt  = 16'h8000;
      lag_pos = 16'h8000;
    end else begin
      case (m_mode)
        0: begin
          m_done = 0;
          if (start) begin
            m_dir  = dir;
            m_p    = (period == 16'd0) ? 1 : int'(period);
            m_n    = int'(nsteps);
            m_s    = cyc;
            m_emit = 0;
            if (m_n == 0) begin
              m_mode = 2;
              m_done = 1;
            end else begin
              m_mode = 1;
              m_busy = 1;
            end
          end
        end
        1: begin
          if ((cyc - m_s) % m_p == 0) begin
            m_phase = m_dir ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
            m_pos   = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
            m_emit++;
          end
          if (m_emit == m_n || abort) begin
            m_mode = 2;
            m_busy = 0;
            m_done = 1;
          end
        end
        default: begin
          m_done = 0;
          m_mode = 0;
        end
      endcase
      begin
        int cur, d;
        cur = ab_idx(encA, encB);
        d   = (cur - rd_prev + 4) % 4;
        if (d == 1) rd_cnt = rd_cnt + 16'd1;
        if (d == 3) rd_cnt = rd_cnt - 16'd1;
        rd_prev = cur;
        lag_pos = pos;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("outputs", {12'd0, encA, encB, busy, done, pos},
            {12'd0, ab_tab[m_phase], m_busy, m_done, m_pos});
      check("reader", {16'd0, rd_cnt}, {16'd0, lag_pos});
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic go(input logic d, input logic [15:0] n, input logic [15:0] p);
    dir    = d;
    nsteps = n;
    period = p;
    start  = 1'b1;
    cyc_wait(1);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (!done && k < budget) begin
      cyc_wait(1);
      k++;
    end
    check(name, done, 1);
  endtask

  task automatic wait_pos(input logic [15:0] target, input int budget, input string name);
    int k = 0;
    while (pos !== target && k < budget) begin
      cyc_wait(1);
      k++;
    end
    check(name, pos, target);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    cyc_wait(1);
    rst = 1'b0;
  endtask

  initial begin
    int d0, b0;
    rst = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0;
    nsteps = '0; period = '0;
    cyc_wait(3);
    rst = 1'b0;
    cyc_wait(1);
    check("rst_ab", {encA, encB}, 2'b00);
    check("rst_pos", pos, 16'h8000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Forward 8 edges, period 4.
    d0 = done_cnt;
    go(1'b1, 16'd8, 16'd4);
    check("t1_busy", busy, 1);
    wait_done(100, "t1_done");
    check("t1_pos", pos, 16'h8008);
    check("t1_ab", {encA, encB}, 2'b00);
    cyc_wait(2);
    check("t1_done_cnt", done_cnt - d0, 1);

    // Reverse 3 edges at period 0 (one per clock).
    reset_pulse();
    b0 = busy_cnt;
    go(1'b0, 16'd3, 16'd0);
    wait_done(20, "t2_done");
    check("t2_pos", pos, 16'h7FFD);
    check("t2_ab", {encA, encB}, 2'b10);
    cyc_wait(2);
    check("t2_busy_cycles", busy_cnt - b0, 3);

    // Zero-length move.
    d0 = done_cnt;
    b0 = busy_cnt;
    go(1'b1, 16'd0, 16'd5);
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    check("t3_pos", pos, 16'h7FFD);
    check("t3_ab", {encA, encB}, 2'b10);
    cyc_wait(2);
    check("t3_done_cnt", done_cnt - d0, 1);
    check("t3_busy_cycles", busy_cnt - b0, 0);

    // Abort after 5 edges, then a 1-step move continues the phase.
    reset_pulse();
    d0 = done_cnt;
    go(1'b1, 16'd100, 16'd2);
    wait_pos(16'h8005, 50, "t4_reach");
    abort = 1'b1;
    cyc_wait(1);
    abort = 1'b0;
    check("t4_done", done, 1);
    check("t4_pos", pos, 16'h8005);
    check("t4_ab", {encA, encB}, 2'b10);
    cyc_wait(3);
    check("t4_hold_ab", {encA, encB}, 2'b10);
    check("t4_done_cnt", done_cnt - d0, 1);
    go(1'b1, 16'd1, 16'd7);
    wait_done(20, "t4b_done");
    check("t4b_ab", {encA, encB}, 2'b11);
    check("t4b_pos", pos, 16'h8006);
    cyc_wait(2);

    // Abort in the same cycle an edge is due: the edge is still emitted.
    go(1'b1, 16'd100, 16'd1);
    abort = 1'b1;
    cyc_wait(1);
    abort = 1'b0;
    check("t4c_done", done, 1);
    check("t4c_pos", pos, 16'h8007);
    check("t4c_ab", {encA, encB}, 2'b01);
    cyc_wait(2);

    // Reset mid-move; a start during RUN is ignored.
    reset_pulse();
    go(1'b1, 16'd10, 16'd3);
    go(1'b0, 16'd2, 16'd1);
    wait_pos(16'h8003, 40, "t5_reach");
    rst = 1'b1;
    cyc_wait(1);
    rst = 1'b0;
    check("t5_ab", {encA, encB}, 2'b00);
    check("t5_pos", pos, 16'h8000);
    check("t5_busy", busy, 0);
    d0 = done_cnt;
    cyc_wait(5);
    check("t5_no_done", done_cnt - d0, 0);

    // Reverse wrap through zero: 0x8001 steps from 0x8000.
    reset_pulse();
    go(1'b0, 16'h8001, 16'd1);
    wait_done(33000, "t6_done");
    check("t6_pos", pos, 16'hFFFF);
    check("t6_ab", {encA, encB}, 2'b01);
    cyc_wait(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
